// File: rtl/nco_hop_sched.sv
`default_nettype none
// ============================================================================
//  Module   : nco_hop_sched
//  Purpose  : Frequency-hop scheduler for the NCO datapath. Holds a table of
//             phase-increment/dwell pairs and steps p_inc_o through it on
//             command, optionally looping. Flags the CORDIC settling window
//             after every hop.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        clock
//    rst_i        synchronous reset, active low
//    cfg_we_i     table write strobe (accepted only while idle)
//    cfg_addr_i   table write address
//    cfg_pinc_i   phase increment to store
//    cfg_dwell_i  dwell to store (0 behaves as 1)
//    cfg_len_i    hop count, sampled on an accepted start
//    loop_i       wrap to entry 0 after the last hop, sampled on start
//    start_i      start pulse
//    stop_i       abort pulse
//    p_inc_o      phase increment to the phase accumulator
//    pinc_stb_o   one-cycle pulse whenever p_inc_o changes
//    settle_o     NCO output invalid after a hop
//    hop_idx_o    index of the entry driving p_inc_o
//    busy_o       sequencing in progress
//    done_o       one-cycle pulse on natural completion
//    cfg_err_o    one-cycle pulse when a table write is rejected
// ============================================================================
module nco_hop_sched #(
    parameter int DEPTH   = 8,
    parameter int PINC_W  = 32,
    parameter int DWELL_W = 16,
    parameter int SETTLE  = 20,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_we_i,
    input  logic [AW-1:0]      cfg_addr_i,
    input  logic [PINC_W-1:0]  cfg_pinc_i,
    input  logic [DWELL_W-1:0] cfg_dwell_i,
    input  logic [AW:0]        cfg_len_i,
    input  logic               loop_i,
    input  logic               start_i,
    input  logic               stop_i,
    output logic [PINC_W-1:0]  p_inc_o,
    output logic               pinc_stb_o,
    output logic               settle_o,
    output logic [AW-1:0]      hop_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               cfg_err_o
);

    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [PINC_W-1:0]  pinc_tab  [DEPTH];
    logic [DWELL_W-1:0] dwell_tab [DEPTH];

    logic [AW-1:0]      idx;
    logic [AW:0]        len;
    logic               loop_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [SW-1:0]      settle_cnt;

    logic start_go;
    logic abort_go;
    logic is_last;

    // Current entry is the final one of the pass when idx+1 reaches len.
    assign is_last = (({1'b0, idx} + (AW+1)'(1)) >= len);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        start_go = 1'b0;
        abort_go = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !stop_i && (cfg_len_i != '0)) begin
                    state_n  = LOAD;
                    start_go = 1'b1;
                end
            end
            LOAD:  state_n = DWELL;
            DWELL: begin
                if (dwell_cnt == DWELL_W'(1)) begin
                    state_n = (is_last && !loop_q) ? DONE : LOAD;
                end
            end
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Abort overrides every other transition once a run is active.
        if ((state != IDLE) && stop_i) begin
            state_n  = IDLE;
            abort_go = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pinc_tab[i]  <= '0;
                dwell_tab[i] <= '0;
            end
            idx        <= '0;
            len        <= '0;
            loop_q     <= 1'b0;
            dwell_cnt  <= '0;
            settle_cnt <= '0;
            p_inc_o    <= '0;
            pinc_stb_o <= 1'b0;
            settle_o   <= 1'b0;
            hop_idx_o  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            pinc_stb_o <= 1'b0;
            done_o     <= 1'b0;
            busy_o     <= (state_n != IDLE);
            cfg_err_o  <= cfg_we_i && (state != IDLE);

            // Table is frozen while a run is active.
            if (cfg_we_i && (state == IDLE)) begin
                pinc_tab[cfg_addr_i]  <= cfg_pinc_i;
                dwell_tab[cfg_addr_i] <= cfg_dwell_i;
            end

            // settle_cnt holds the remaining high cycles including the
            // current one, so settle_o drops after exactly SETTLE cycles.
            if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SW'(1);
            end
            settle_o <= (settle_cnt > SW'(1));

            if (abort_go || (state == DONE)) begin
                p_inc_o    <= '0;
                pinc_stb_o <= 1'b1;
                settle_o   <= 1'b0;
                settle_cnt <= '0;
                hop_idx_o  <= '0;
                done_o     <= !abort_go;
            end else if (state == LOAD) begin
                p_inc_o    <= pinc_tab[idx];
                hop_idx_o  <= idx;
                dwell_cnt  <= (dwell_tab[idx] == '0) ? DWELL_W'(1) : dwell_tab[idx];
                settle_cnt <= SW'(SETTLE);
                settle_o   <= (SETTLE > 0);
                pinc_stb_o <= 1'b1;
            end else if (state == DWELL) begin
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
                if (dwell_cnt == DWELL_W'(1)) begin
                    idx <= is_last ? '0 : idx + AW'(1);
                end
            end

            if (start_go) begin
                len    <= (cfg_len_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_len_i;
                loop_q <= loop_i;
                idx    <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nco_hop_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_nco_hop_sched
//  Purpose  : Self-checking bench for nco_hop_sched. An expected per-cycle
//             output trace is generated from the hop table contents and the
//             run parameters, then compared cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nco_hop_sched;

    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int PINC_W  = 32;
    localparam int DWELL_W = 16;
    localparam int SETTLE  = 20;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_we = 1'b0;
    logic [AW-1:0]      cfg_addr = '0;
    logic [PINC_W-1:0]  cfg_pinc = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [AW:0]        cfg_len = '0;
    logic               loop = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [PINC_W-1:0]  p_inc;
    logic               pinc_stb, settle, busy, done, cfg_err;
    logic [AW-1:0]      hop_idx;

    nco_hop_sched #(
        .DEPTH(DEPTH), .PINC_W(PINC_W), .DWELL_W(DWELL_W), .SETTLE(SETTLE)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_pinc_i(cfg_pinc), .cfg_dwell_i(cfg_dwell), .cfg_len_i(cfg_len),
        .loop_i(loop), .start_i(start), .stop_i(stop), .p_inc_o(p_inc),
        .pinc_stb_o(pinc_stb), .settle_o(settle), .hop_idx_o(hop_idx),
        .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err)
    );

    always #5 clk = ~clk;

    typedef logic [39:0] obs_t;   // {p_inc, stb, settle, idx, busy, done, err}

    int          checks = 0;
    int          errors = 0;
    logic [31:0] pinc_m  [DEPTH];
    int          dwell_m [DEPTH];
    obs_t        exp_q[$];

    function automatic obs_t mk(input logic [31:0] p, input bit stb, input bit st,
                                input int ix, input bit bz, input bit dn, input bit er);
        logic [2:0] i3;
        i3 = ix[2:0];
        return {p, stb, st, i3, bz, dn, er};
    endfunction

    // Expected trace starting with the cycle after the accepted start edge.
    function automatic void build_trace(input int len_req, input bit lp, input int maxcyc);
        int n, ix, d;
        exp_q.delete();
        n = (len_req > DEPTH) ? DEPTH : len_req;
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        ix = 0;
        while (exp_q.size() < maxcyc) begin
            d = (dwell_m[ix] == 0) ? 1 : dwell_m[ix];
            for (int c = 0; c <= d; c++)
                exp_q.push_back(mk(pinc_m[ix], c == 0, c < SETTLE, ix, 1, 0, 0));
            ix++;
            if (ix == n) begin
                if (lp) ix = 0;
                else begin
                    exp_q.push_back(mk(0, 1, 0, 0, 0, 1, 0));
                    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                    break;
                end
            end
        end
        while (exp_q.size() > maxcyc) void'(exp_q.pop_back());
    endfunction

    task automatic step_obs(output obs_t o);
        @(posedge clk);
        #1;
        o = {p_inc, pinc_stb, settle, hop_idx, busy, done, cfg_err};
    endtask

    task automatic write_entry(input int a, input logic [31:0] p, input int d);
        obs_t o;
        cfg_we = 1; cfg_addr = a[AW-1:0]; cfg_pinc = p; cfg_dwell = d[DWELL_W-1:0];
        step_obs(o);
        cfg_we = 0;
        pinc_m[a] = p; dwell_m[a] = d;
    endtask

    task automatic start_run(input int n, input bit lp, output obs_t o);
        cfg_len = n[AW:0]; loop = lp; start = 1;
        step_obs(o);
        start = 0;
    endtask

    task automatic clear_model;
        for (int i = 0; i < DEPTH; i++) begin pinc_m[i] = 0; dwell_m[i] = 0; end
    endtask

    task automatic test_reset;
        obs_t o;
        write_entry(0, 32'hDEADBEEF, 3);
        start_run(1, 0, o);
        step_obs(o);
        rst = 0;
        repeat (3) step_obs(o);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_outputs got %h exp %h", o, obs_t'(0)); end
        rst = 1;
        clear_model();
        build_trace(1, 0, 100);
        start_run(1, 0, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) step_obs(o);
            checks++;
            if (o !== exp_q[i]) begin errors++; $display("FAIL reset_table cyc %0d got %h exp %h", i, o, exp_q[i]); end
        end
    endtask

    task automatic test_single_pass;
        obs_t o;
        write_entry(0, 32'h33333333, 4);
        write_entry(1, 32'h11111111, 2);
        write_entry(2, 32'h80000000, 0);
        build_trace(3, 0, 1000);
        start_run(3, 0, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) step_obs(o);
            checks++;
            if (o !== exp_q[i]) begin errors++; $display("FAIL single_pass cyc %0d got %h exp %h", i, o, exp_q[i]); end
        end
    endtask

    task automatic test_loop_stop;
        obs_t o;
        build_trace(2, 1, 25);
        start_run(2, 1, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) step_obs(o);
            checks++;
            if (o !== exp_q[i]) begin errors++; $display("FAIL loop cyc %0d got %h exp %h", i, o, exp_q[i]); end
        end
        stop = 1;
        step_obs(o);
        stop = 0;
        checks++;
        if (o !== mk(0, 1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL stop_edge got %h exp %h", o, mk(0, 1, 0, 0, 0, 0, 0)); end
        step_obs(o);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL stop_after got %h exp %h", o, obs_t'(0)); end
    endtask

    task automatic test_settle;
        obs_t o;
        write_entry(0, 32'h01234567, 100);
        build_trace(1, 0, 1000);
        start_run(1, 0, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) step_obs(o);
            checks++;
            if (o !== exp_q[i]) begin errors++; $display("FAIL settle_long cyc %0d got %h exp %h", i, o, exp_q[i]); end
        end
        for (int a = 0; a < 3; a++) write_entry(a, $urandom, 5);
        build_trace(3, 0, 1000);
        start_run(3, 0, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) step_obs(o);
            checks++;
            if (o !== exp_q[i]) begin errors++; $display("FAIL settle_short cyc %0d got %h exp %h", i, o, exp_q[i]); end
        end
    endtask

    task automatic test_rejected;
        obs_t o;
        write_entry(0, $urandom, 10);
        write_entry(1, $urandom, 10);
        build_trace(2, 0, 1000);
        exp_q[4] = exp_q[4] | obs_t'(1);
        start_run(2, 0, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) step_obs(o);
            checks++;
            if (o !== exp_q[i]) begin errors++; $display("FAIL reject cyc %0d got %h exp %h", i, o, exp_q[i]); end
            if (i == 3) begin
                cfg_we = 1; cfg_addr = 0; cfg_pinc = 32'hBADC0DE5; cfg_dwell = 1;
                cfg_len = 1; start = 1;
            end else if (i == 4) begin
                cfg_we = 0; start = 0;
            end
        end
        build_trace(2, 0, 1000);
        start_run(2, 0, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) step_obs(o);
            checks++;
            if (o !== exp_q[i]) begin errors++; $display("FAIL reject_rerun cyc %0d got %h exp %h", i, o, exp_q[i]); end
        end
        start_run(0, 0, o);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL len_zero got %h exp %h", o, obs_t'(0)); end
        step_obs(o);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL len_zero_after got %h exp %h", o, obs_t'(0)); end
    endtask

    task automatic test_collisions;
        obs_t o;
        int   k;
        stop = 1;
        start_run(3, 0, o);
        stop = 0;
        checks++;
        if (o !== '0) begin errors++; $display("FAIL start_stop got %h exp %h", o, obs_t'(0)); end
        step_obs(o);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL start_stop_after got %h exp %h", o, obs_t'(0)); end
        // Stop during DONE: the cycle just before the done pulse appears.
        write_entry(0, 32'h0F0F0F0F, 3);
        build_trace(1, 0, 1000);
        k = exp_q.size() - 3;
        start_run(1, 0, o);
        for (int i = 0; i <= k; i++) begin
            if (i > 0) step_obs(o);
            checks++;
            if (o !== exp_q[i]) begin errors++; $display("FAIL stop_done cyc %0d got %h exp %h", i, o, exp_q[i]); end
        end
        stop = 1;
        step_obs(o);
        stop = 0;
        checks++;
        if (o !== mk(0, 1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL stop_done_edge got %h exp %h", o, mk(0, 1, 0, 0, 0, 0, 0)); end
        step_obs(o);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL stop_done_after got %h exp %h", o, obs_t'(0)); end
        // Length beyond the table is clamped.
        for (int a = 0; a < DEPTH; a++) write_entry(a, $urandom, $urandom_range(0, 3));
        build_trace(15, 0, 1000);
        start_run(15, 0, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) step_obs(o);
            checks++;
            if (o !== exp_q[i]) begin errors++; $display("FAIL clamp cyc %0d got %h exp %h", i, o, exp_q[i]); end
        end
    endtask

    task automatic test_random;
        obs_t o;
        int   n;
        bit   lp;
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < DEPTH; a++) write_entry(a, $urandom, $urandom_range(0, 7));
            n  = $urandom_range(1, 15);
            lp = $urandom_range(0, 1);
            build_trace(n, lp, lp ? $urandom_range(10, 60) : 10000);
            start_run(n, lp, o);
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) step_obs(o);
                checks++;
                if (o !== exp_q[i]) begin errors++; $display("FAIL random it %0d cyc %0d got %h exp %h", it, i, o, exp_q[i]); end
            end
            if (lp) begin
                stop = 1;
                step_obs(o);
                stop = 0;
                checks++;
                if (o !== mk(0, 1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL random_stop it %0d got %h exp %h", it, o, mk(0, 1, 0, 0, 0, 0, 0)); end
                step_obs(o);
            end
        end
    endtask

    initial begin
        clear_model();
        rst = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        test_reset();
        test_single_pass();
        test_loop_stop();
        test_settle();
        test_rejected();
        test_collisions();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/nco_hop_sched.md
# nco_hop_sched

Frequency-hop scheduler for the NCO datapath (phase accumulator + 4 parallel CORDIC lanes). It holds a small table of phase-increment/dwell pairs, loaded through a simple write port. On command it steps the phase accumulator's `p_inc_i` through the table, optionally looping. It flags the CORDIC pipeline-settling window after every hop so downstream consumers can discard transient samples.

## Interface
Parameters:
- `DEPTH`, 8: hop table entries, power of two, 2..64; `AW = $clog2(DEPTH)`.
- `PINC_W`, 32: phase-increment width; matches the phase accumulator.
- `DWELL_W`, 16: dwell counter width, in clk cycles.
- `SETTLE`, 20: cycles of `settle_o` after each hop; must be ≥ CORDIC latency + 1; 0 disables.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous reset, active-low.
- `cfg_we_i` in 1: table write strobe.
- `cfg_addr_i` in AW: table write address.
- `cfg_pinc_i` in PINC_W: phase increment to store.
- `cfg_dwell_i` in DWELL_W: dwell to store; 0 is treated as 1.
- `cfg_len_i` in AW+1: number of hops to run; sampled on an accepted `start_i`.
- `loop_i` in 1: 1 = wrap to entry 0 after the last hop; sampled on an accepted `start_i`.
- `start_i` in 1: start pulse.
- `stop_i` in 1: abort pulse.
- `p_inc_o` out PINC_W: phase increment to the phase accumulator.
- `pinc_stb_o` out 1: 1-cycle pulse whenever `p_inc_o` changes.
- `settle_o` out 1: high while the NCO output is invalid after a hop.
- `hop_idx_o` out AW: index of the entry currently driving `p_inc_o`.
- `busy_o` out 1: sequencing in progress.
- `done_o` out 1: 1-cycle pulse on natural completion.
- `cfg_err_o` out 1: 1-cycle pulse when a write is rejected.

## Operation
- The table is DEPTH × (PINC_W+DWELL_W) registers, cleared to 0 by reset.
- Writes are accepted only in IDLE.
  - `cfg_we_i` in any other state is dropped.
  - A dropped write pulses `cfg_err_o` on the next cycle.
- States: IDLE, LOAD, DWELL, DONE.
- IDLE: `busy_o`=0.
  - On `start_i` with `stop_i`=0 and `cfg_len_i`≠0: latch len = min(`cfg_len_i`, DEPTH), latch loop, set idx=0, go to LOAD.
  - `start_i` with `cfg_len_i`=0 is ignored.
- LOAD (1 cycle): at exit, register the following, then go to DWELL:
  - `p_inc_o` ← table[idx].pinc
  - `hop_idx_o` ← idx
  - dwell_cnt ← max(table[idx].dwell, 1)
  - settle_cnt ← SETTLE
  - `pinc_stb_o` ← 1
- DWELL: dwell_cnt decrements each cycle. Settle_cnt decrements while nonzero; `settle_o` = (settle_cnt≠0). When dwell_cnt = 1:
  - If idx < len−1: idx+1, go to LOAD.
  - Else if loop: idx ← 0, go to LOAD.
  - Else: go to DONE.
- DONE (1 cycle): at exit, `p_inc_o` ← 0, `pinc_stb_o` ← 1, `done_o` ← 1, `settle_o` ← 0, `hop_idx_o` ← 0, go to IDLE.
- `stop_i` in LOAD, DWELL or DONE: next state is IDLE. At that edge:
  - `p_inc_o` ← 0, `pinc_stb_o` ← 1, `settle_o` ← 0, `hop_idx_o` ← 0.
  - No `done_o`.
  - Stop has priority over every other transition, including `start_i` and the DONE exit.
- `stop_i` in IDLE: no effect.
- `start_i` while busy: ignored.
- `busy_o` = 1 in LOAD, DWELL and DONE.
- All outputs are registered. The table is read only in LOAD; table contents cannot change while busy.

## Timing
- Reset values: `p_inc_o`=0, `pinc_stb_o`=0, `settle_o`=0, `hop_idx_o`=0, `busy_o`=0, `done_o`=0, `cfg_err_o`=0; state IDLE.
- Start latency: `start_i` high at edge N → LOAD during N+1.
  - `busy_o` rises after edge N.
  - `p_inc_o`/`pinc_stb_o` updated after edge N+1.
- Hop period: `p_inc_o` holds each entry for max(dwell,1)+1 cycles (DWELL + the next LOAD).
  - With loop, the last→first wrap has the same period, with no gap.
- Settle timing: `settle_o` rises with `pinc_stb_o` and stays high for min(SETTLE, hop period) cycles. A new hop restarts it.
- Completion: after the last dwell, DONE lasts 1 cycle. `done_o`, `pinc_stb_o` and `p_inc_o`=0 appear together, and `busy_o` falls in that same cycle.
- Stop latency: 1 edge.
- Reset mid-run: returns all outputs to reset values at the next edge and clears the table.

## Test plan
- Reset: `rst_i`=0 for 3 cycles → all outputs 0 and table reads 0. A run with `cfg_len_i`=1 then outputs `p_inc_o`=0 for 2 cycles.
- Single pass: write {0x33333333, 4}, {0x11111111, 2}, {0x80000000, 0}; `cfg_len_i`=3, loop=0; start. Required response:
  - `p_inc_o` sequence 0x33333333 ×5, 0x11111111 ×3, 0x80000000 ×2, then 0.
  - `hop_idx_o` 0, 1, 2.
  - `pinc_stb_o` at each change; `done_o` once.
- Loop and stop: same table, `cfg_len_i`=2, loop=1 → hop_idx 0, 1, 0, 1, … with no gaps. `stop_i` mid-DWELL → next cycle `p_inc_o`=0, `busy_o`=0, no `done_o`.
- Settle: SETTLE=20, dwell=100 → `settle_o` high exactly 20 cycles from each `pinc_stb_o`. With dwell=5, `settle_o` stays high continuously across hops.
- Rejected config: `cfg_we_i` during DWELL → `cfg_err_o` pulse, and the table is unchanged on the next run. `start_i` while busy → ignored. `start_i` with `cfg_len_i`=0 → `busy_o` stays 0.
- Collisions: `start_i` and `stop_i` in the same IDLE cycle → stays IDLE. `stop_i` in the DONE cycle → IDLE, no `done_o`. `cfg_len_i`=15 with DEPTH=8 → clamped to 8 hops.
